// File: rtl/alu_operand_stage.sv
// EX-stage operand generator: forwards rs/rt from MEM/WB, selects ALU A/B,
// stalls ID on load-use hazards and registers the pair under valid/ready.

module alu_fwd_unit #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              mem_wen,
   input  logic [REG_AW-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              wb_wen,
   input  logic [REG_AW-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   output logic [DATA_W-1:0] fwd_data,
   output logic              mem_hit
);
   logic addr_nz;
   logic wb_hit;

   assign addr_nz = (addr != '0);
   assign mem_hit = addr_nz & mem_wen & (mem_waddr == addr);
   assign wb_hit  = addr_nz & wb_wen & (wb_waddr == addr);

   // MEM is the younger producer, so it wins over WB.
   always_comb begin
      fwd_data = rf_data;
      if (!addr_nz)     fwd_data = '0;
      else if (mem_hit) fwd_data = mem_wdata;
      else if (wb_hit)  fwd_data = wb_wdata;
   end
endmodule

module alu_operand_stage #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int SHIFT_CONST = 16,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alua_sel,
   input  logic [1:0]        alub_sel,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [DATA_W-1:0] rdata1,
   input  logic [DATA_W-1:0] rdata2,
   input  logic [DATA_W-1:0] ext_imm,
   input  logic              mem_wen,
   input  logic [REG_AW-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_is_load,
   input  logic              wb_wen,
   input  logic [REG_AW-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int NUM_SRC = 2;
   localparam logic [1:0] A_RS = 2'b00, A_RT = 2'b01, A_IMM = 2'b10;
   localparam logic [1:0] B_RT = 2'b00, B_IMM = 2'b01, B_ZERO = 2'b10;
   localparam logic [DATA_W-1:0] SHIFT_VAL = DATA_W'(SHIFT_CONST);

   logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
   logic [NUM_SRC-1:0][DATA_W-1:0] src_rdata;
   logic [NUM_SRC-1:0][DATA_W-1:0] src_val;
   logic [NUM_SRC-1:0]             src_mem_hit;
   logic [NUM_SRC-1:0]             src_used;

   logic              hazard, capture;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] alu_a_d, alu_a_q, alu_b_d, alu_b_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

   // Index 0 is rs, index 1 is rt.
   assign src_addr  = {rt_addr, rs_addr};
   assign src_rdata = {rdata2, rdata1};
   assign src_used[0] = (alua_sel == A_RS);
   assign src_used[1] = (alua_sel == A_RT) | (alub_sel == B_RT);

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      alu_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
         .addr      (src_addr[g]),
         .rf_data   (src_rdata[g]),
         .mem_wen   (mem_wen),
         .mem_waddr (mem_waddr),
         .mem_wdata (mem_wdata),
         .wb_wen    (wb_wen),
         .wb_waddr  (wb_waddr),
         .wb_wdata  (wb_wdata),
         .fwd_data  (src_val[g]),
         .mem_hit   (src_mem_hit[g])
      );
   end

   // A load in MEM has no data yet; WB data is always ready to forward.
   assign hazard   = in_valid & mem_is_load & |(src_used & src_mem_hit);
   assign in_ready = !rst & !hazard & (!out_valid_q | out_ready);
   assign capture  = in_valid & in_ready & !flush;

   always_comb begin
      case (alua_sel)
         A_RS:    sel_a = src_val[0];
         A_RT:    sel_a = src_val[1];
         A_IMM:   sel_a = ext_imm;
         default: sel_a = '0;
      endcase
      case (alub_sel)
         B_RT:    sel_b = src_val[1];
         B_IMM:   sel_b = ext_imm;
         B_ZERO:  sel_b = '0;
         default: sel_b = SHIFT_VAL;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d = 1'b1;
         alu_a_d     = sel_a;
         alu_b_d     = sel_b;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (hazard && !flush && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage; a second instance with a
// 2-bit counter shares all inputs to exercise stall counter saturation.

module tb_alu_operand_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush, in_valid, out_ready;
   logic [1:0]  alua_sel, alub_sel;
   logic [4:0]  rs_addr, rt_addr, mem_waddr, wb_waddr;
   logic [31:0] rdata1, rdata2, ext_imm, mem_wdata, wb_wdata;
   logic        mem_wen, mem_is_load, wb_wen;

   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [31:0] alu_a, alu_b, alu_a2, alu_b2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alua_sel(alua_sel), .alub_sel(alub_sel), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rdata1(rdata1), .rdata2(rdata2), .ext_imm(ext_imm),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .stall_cnt(stall_cnt)
   );

   alu_operand_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .alua_sel(alua_sel), .alub_sel(alub_sel), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rdata1(rdata1), .rdata2(rdata2), .ext_imm(ext_imm),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid2), .out_ready(out_ready), .alu_a(alu_a2), .alu_b(alu_b2),
      .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      flush = 0; in_valid = 0; out_ready = 1;
      alua_sel = 2'b11; alub_sel = 2'b10;
      rs_addr = 0; rt_addr = 0; rdata1 = 0; rdata2 = 0; ext_imm = 0;
      mem_wen = 0; mem_waddr = 0; mem_wdata = 0; mem_is_load = 0;
      wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
   endtask

   initial begin
      clr_in();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      step(); step();
      rst = 1'b0;

      // Basic capture
      alua_sel = 2'b00; rs_addr = 3; rdata1 = 32'h11;
      alub_sel = 2'b01; ext_imm = 32'h22; in_valid = 1;
      #1 chk("basic_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("basic_a", alu_a, 32'h11);
      chk("basic_b", alu_b, 32'h22);
      chk("basic_valid", 32'(out_valid), 32'd1);

      // Asynchronous reset mid-cycle discards the pair
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_a", alu_a, 32'd0);
      chk("arst_b", alu_b, 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      #1 rst = 1'b0;
      step();

      // Forwarding priority MEM > WB > regfile, zero register
      clr_in();
      in_valid = 1; alua_sel = 2'b00; rs_addr = 5; rdata1 = 32'h1111;
      mem_wen = 1; mem_waddr = 5; mem_wdata = 32'hAAAA;
      wb_wen = 1; wb_waddr = 5; wb_wdata = 32'hBBBB;
      step();
      chk("fwd_mem_a", alu_a, 32'hAAAA);
      chk("fwd_mem_b", alu_b, 32'h0);
      mem_wen = 0;
      step();
      chk("fwd_wb_a", alu_a, 32'hBBBB);
      mem_wen = 1; rs_addr = 0; mem_waddr = 0; wb_waddr = 0; rdata1 = 32'hDEAD;
      step();
      chk("fwd_r0_a", alu_a, 32'h0);

      // Load-use hazard on rt via B
      clr_in();
      in_valid = 1; mem_is_load = 1; mem_wen = 1; mem_waddr = 7; mem_wdata = 32'h5;
      rt_addr = 7; rdata2 = 32'h5; alub_sel = 2'b00; alua_sel = 2'b11;
      #1 chk("lu_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      chk("lu_drain_valid", 32'(out_valid), 32'd0);
      mem_is_load = 0; mem_wen = 0; wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h77;
      #1 chk("lu_resume_ready", 32'(in_ready), 32'd1);
      step();
      chk("lu_b", alu_b, 32'h77);
      chk("lu_a", alu_a, 32'h0);
      chk("lu_valid", 32'(out_valid), 32'd1);

      // Same load in MEM but rt/rs unused
      clr_in();
      in_valid = 1; mem_is_load = 1; mem_wen = 1; mem_waddr = 7;
      rt_addr = 7; rs_addr = 7; alua_sel = 2'b10; alub_sel = 2'b01; ext_imm = 32'h99;
      #1 chk("nolu_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("nolu_a", alu_a, 32'h99);
      chk("nolu_b", alu_b, 32'h99);
      chk("nolu_cnt", 32'(stall_cnt), 32'd1);

      // LUI shift constant
      clr_in();
      in_valid = 1; alua_sel = 2'b10; ext_imm = 32'h1234; alub_sel = 2'b11;
      step();
      chk("lui_a", alu_a, 32'h1234);
      chk("lui_b", alu_b, 32'd16);

      // Back-pressure holds the pair
      out_ready = 0; alua_sel = 2'b00; rs_addr = 3; alub_sel = 2'b01;
      for (int k = 0; k < 3; k++) begin
         rdata1 = 32'h100 + k; ext_imm = 32'h200 + k;
         wb_wen = 1; wb_waddr = 3; wb_wdata = 32'h300 + k;
         #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
         step();
         chk("bp_a", alu_a, 32'h1234);
         chk("bp_b", alu_b, 32'd16);
         chk("bp_valid", 32'(out_valid), 32'd1);
      end
      clr_in();
      in_valid = 1; alua_sel = 2'b00; rs_addr = 3; rdata1 = 32'hCAFE; alub_sel = 2'b10;
      #1 chk("bp_rel_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_rel_a", alu_a, 32'hCAFE);
      chk("bp_rel_b", alu_b, 32'h0);
      chk("bp_rel_valid", 32'(out_valid), 32'd1);

      // Flush drops held and incoming
      flush = 1; out_ready = 0; rdata1 = 32'hBEEF;
      step();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_stale_a", alu_a, 32'hCAFE);

      // Sustained hazard: 5 counted cycles, then one flushed cycle
      clr_in();
      in_valid = 1; mem_is_load = 1; mem_wen = 1; mem_waddr = 9;
      rs_addr = 9; alua_sel = 2'b00;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("sat_cnt16", 32'(stall_cnt), 32'(2 + k));
         chk("sat_cnt2", 32'(stall_cnt2), (k >= 1) ? 32'd3 : 32'd2);
         chk("sat_valid", 32'(out_valid), 32'd0);
      end
      flush = 1;
      step();
      chk("flush_cnt16", 32'(stall_cnt), 32'd6);
      chk("flush_cnt2", 32'(stall_cnt2), 32'd3);
      flush = 0; in_valid = 0;
      step();
      chk("idle_cnt16", 32'(stall_cnt), 32'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered EX-stage operand generator for the CPU pipeline.
- Selects the ALU A and B operands from register-file data, the extended immediate, zero, or a shift constant (for LUI). Before selection, register operands are resolved through MEM- and WB-stage forwarding.
- Detects load-use hazards and back-pressures the ID stage. Results are held in an output register under a valid/ready handshake, with flush support and a saturating hazard-stall counter.

Parameters:
DATA_W, 32, datapath width of operands and forwarded data
REG_AW, 5, register address width; address 0 is the hardwired zero register
SHIFT_CONST, 16, constant driven on B for select 2'b11 (LUI), zero-extended to DATA_W
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  drop held and incoming operands (branch/exception)
in_valid  in  1  ID stage offers an instruction
in_ready  out  1  stage accepts the instruction this cycle
alua_sel  in  2  A select: 00 rs value, 01 rt value, 10 ext_imm, 11 zero
alub_sel  in  2  B select: 00 rt value, 01 ext_imm, 10 zero, 11 SHIFT_CONST
rs_addr  in  REG_AW  source register 1 address
rt_addr  in  REG_AW  source register 2 address
rdata1  in  DATA_W  register-file read port 1
rdata2  in  DATA_W  register-file read port 2
ext_imm  in  DATA_W  extended immediate
mem_wen  in  1  MEM-stage instruction writes a register
mem_waddr  in  REG_AW  MEM-stage destination
mem_wdata  in  DATA_W  MEM-stage result
mem_is_load  in  1  MEM-stage instruction is a load; its data is not yet available
wb_wen  in  1  WB-stage write enable
wb_waddr  in  REG_AW  WB-stage destination
wb_wdata  in  DATA_W  WB-stage data
out_valid  out  1  alu_a/alu_b hold a valid operand pair
out_ready  in  1  ALU consumes the pair
alu_a  out  DATA_W  registered ALU operand A
alu_b  out  DATA_W  registered ALU operand B
stall_cnt  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, alu_a=0, alu_b=0, stall_cnt=0.
  - in_ready=0 while rst is asserted.
  - Reset mid-transfer discards the pending pair.
- Forwarding (combinational, per source, applied independently to rs and rt):
  - If the address is 0, the value is 0 regardless of any other input.
  - Else if mem_wen and mem_waddr==addr, the value is mem_wdata (MEM has priority).
  - Else if wb_wen and wb_waddr==addr, the value is wb_wdata.
  - Else the value is the register-file data.
- Operand use:
  - rs is used iff alua_sel==00.
  - rt is used iff alua_sel==01 or alub_sel==00.
- Hazard:
  - hazard = in_valid & mem_is_load & mem_wen & (a used source with nonzero address matches mem_waddr).
  - The WB stage never causes a hazard.
- Handshake:
  - in_ready = !rst & !hazard & (!out_valid | out_ready).
  - Capture occurs iff in_valid & in_ready & !flush.
  - Capture loads alu_a/alu_b with the selected values and sets out_valid=1 on the next edge; latency is 1 cycle.
  - If out_valid & out_ready with no capture, out_valid goes to 0.
  - If out_valid & !out_ready, alu_a/alu_b/out_valid hold unchanged; rdata and forward inputs may change freely without effect.
  - Simultaneous consume and capture: the new pair replaces the old one and out_valid stays 1 (full throughput, one per cycle).
- Flush:
  - Has priority over everything except rst.
  - Next edge: out_valid=0 and no capture.
  - alu_a/alu_b keep their stale values (don't-care when invalid).
- Stall counter:
  - Increments by 1 on every edge where hazard=1 and flush=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
- Selection widths: the constant and zero are DATA_W wide; no sign extension is performed in this block.

Test Plan:
- Reset/basic: rst pulse asynchronously mid-cycle gives out_valid=0, alu_a=alu_b=0 immediately. Then rs=3, rdata1=0x11, alub_sel=01, ext_imm=0x22, out_ready=1 → next cycle alu_a=0x11, alu_b=0x22, out_valid=1.
- Forward priority: rs=5, mem_wen=1, mem_waddr=5, mem_wdata=0xAAAA; wb_wen=1, wb_waddr=5, wb_wdata=0xBBBB → alu_a=0xAAAA. Repeat with rs=0 → alu_a=0.
- Load-use: mem_is_load=1, mem_waddr=7, rt=7, alub_sel=00 → in_ready=0 for that cycle and stall_cnt goes 0→1. Next cycle mem_is_load=0, wb forwards 0x77 → alu_b=0x77. Same setup with alub_sel=01 and alua_sel=10 → no stall.
- LUI constant: alua_sel=10, ext_imm=0x1234, alub_sel=11 → alu_a=0x1234, alu_b=16.
- Back-pressure: out_ready=0 for 3 cycles with changing inputs → alu_a/alu_b unchanged and in_ready=0. Then out_ready=1 with in_valid → new pair captured and out_valid stays 1.
- Flush and saturation: flush with in_valid=1 → out_valid=0 next cycle. With CNT_W=2, hold the hazard for 5 cycles → stall_cnt=3.
